alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Command-side front end for the 16-bit ALU datapath. It buffers incoming {opcode, a, b} commands in a small FIFO and drives one command at a time into the combinational ALU through an issue register. It captures the ALU result and flags into an output register behind a valid/ready handshake, and keeps a sticky status word and a completion counter. Divide/modulus by zero is intercepted here, so downstream logic never consumes an undefined quotient.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_op  in  4  ALU selection code (0 ADD … 14 INVERT, 15 pass a)
- cmd_a, cmd_b  in  16  operands
- alu_a, alu_b  out  16  to ALU a/b (issue register)
- alu_sel  out  4  to ALU selection
- alu_y  in  16  ALU result
- alu_n, alu_z, alu_c, alu_v, alu_e, alu_l  in  1  ALU flags
- res_valid  out  1  result register holds data
- res_ready  in  1  consumer accepts
- res_y  out  16  captured result
- res_flags  out  7  {dz, N, Z, C, V, E, L}, dz in bit 6
- sticky  out  2  {sticky_dz, sticky_v}
- clr_sticky  in  1  synchronous clear of sticky
- done_cnt  out  16  results handed off, wraps at 0xFFFF→0

## Operation
- Accept: cmd_valid & cmd_ready writes {op,a,b} at the FIFO write pointer. cmd_ready = (count < DEPTH).
- Issue register (iv flag): loads FIFO head when FIFO non-empty and (iv==0 or the issue stage advances this cycle). alu_a/alu_b/alu_sel come straight from the register. When iv==0 they hold their last values, and all zero after reset.
- Capture: the issue stage advances when iv & (res_valid==0 or res_ready). The result register then loads alu_y and the flags, and the issue register frees or reloads in the same edge.
- Divide-by-zero: alu_sel ∈ {3,4} with alu_b==0 → res_y=16'hFFFF, dz=1, N=1, Z=0, C=0, V=1, E/L taken from the ALU. Otherwise dz=0 and all fields are passed through from the ALU.
- Handoff: res_valid & res_ready completes a transfer and increments done_cnt. res_valid drops unless a new capture occurs in the same edge.
- Sticky: on each capture, sticky_dz |= dz and sticky_v |= V. If clr_sticky and a capture occur in the same cycle, the capture wins: sticky = the new capture's bits only.
- FIFO occupancy: a simultaneous push and pop leaves count unchanged. A push when full cannot occur, because cmd_ready is low. A pop when empty cannot occur either.
- Order is strict FIFO. No command is dropped or reordered.

## Timing
- Reset (async assert, sync release): FIFO empty, pointers 0, iv=0, res_valid=0, res_y=0, res_flags=0, sticky=0, done_cnt=0, alu_a/alu_b/alu_sel=0, cmd_ready=1.
- Latency: accept on edge k → issue register on edge k+1 → res_valid high after edge k+2 (2 cycles).
- Throughput is 1 result/cycle while res_ready=1.
- Backpressure: with res_ready=0, the result register holds, the issue register holds, and the FIFO fills. cmd_ready falls in the cycle after the DEPTH-th buffered push. Total in flight: DEPTH+2.
- res_y/res_flags are stable while res_valid & ~res_ready.
- Reset mid-operation: all in-flight commands are discarded, and outputs take their reset values immediately (asynchronously).

## Test plan
- Single ADD a=0x7FFF, b=0x0001 → after 2 cycles res_y=0x8000, N=1, V=0, C=0; done_cnt=1 after handoff.
- DIV a=0x1234, b=0 → res_y=0xFFFF, dz=1, V=1; sticky=2'b11. Then clr_sticky alone → sticky=0.
- Burst of 6 commands (SUB, MUL, LSL, ROR, XOR, INVERT) with res_ready=0 and DEPTH=4 → cmd_ready low after the 6th accept. Releasing res_ready yields the 6 results in order, back-to-back, each checked against a software model.
- res_ready toggling 1/0 each cycle during a 20-command stream → no loss or duplication; done_cnt=20; outputs stable while stalled.
- Counter wrap: preload via 65536 handoffs (or force) → done_cnt returns to 0.
- Assert rst with FIFO full and res_valid=1 → same cycle res_valid=0, cmd_ready=1, done_cnt=0. The first post-reset command completes with 2-cycle latency.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Command-side front end for the 16-bit combinational ALU. Incoming
// {opcode, a, b} commands are buffered in a small FIFO. One command at a time
// is driven into the ALU through an issue register. The ALU result and flags
// are captured into a result register that is handed off with valid/ready.
// Divide or modulus by zero is intercepted so that downstream logic never sees
// the ALU's undefined quotient. A sticky status word and a completion counter
// are also kept.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_a, cmd_b     ALU selection code and operands
//   alu_a, alu_b, alu_sel    issue register, drives the ALU inputs
//   alu_y, alu_n .. alu_l    ALU result and flags {N, Z, C, V, E, L}
//   res_valid / res_ready    result handshake
//   res_y, res_flags         captured result, flags {dz, N, Z, C, V, E, L}
//   sticky, clr_sticky       {sticky_dz, sticky_v} and its synchronous clear
//   done_cnt                 number of results handed off (wraps)
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [15:0] alu_y,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    input  logic        alu_e,
    input  logic        alu_l,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_y,
    output logic [6:0]  res_flags,
    output logic [1:0]  sticky,
    input  logic        clr_sticky,
    output logic [15:0] done_cnt
);

    localparam int          PW         = $clog2(DEPTH);
    localparam logic [PW:0] COUNT_FULL = (PW + 1)'(DEPTH);
    localparam logic [3:0]  SEL_DIV    = 4'd3;
    localparam logic [3:0]  SEL_MOD    = 4'd4;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } cmd_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          iv;

    logic          push;
    logic          pop;
    logic          advance;
    logic [15:0]   cap_y;
    logic [6:0]    cap_flags;

    assign cmd_ready = (count < COUNT_FULL);
    assign push      = cmd_valid & cmd_ready;

    // The issue stage moves its command into the result register whenever the
    // result register is empty or is being drained in this same cycle.
    assign advance   = iv & (~res_valid | res_ready);

    // Refill the issue register from the FIFO head when it is empty or
    // emptying this cycle; this pop is also the FIFO read.
    assign pop       = (count != '0) & (~iv | advance);

    assign head      = mem[rd_ptr];

    // NOTE: FIFO storage has no reset; the pointers and count define which
    // entries are live, so resetting the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
        end
    end

    // NOTE: every state register below uses non-blocking assignments so all
    // of them update together from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Issue register. The ALU operands keep their last values while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iv      <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else begin
            if (pop) begin
                iv      <= 1'b1;
                alu_a   <= head.a;
                alu_b   <= head.b;
                alu_sel <= head.op;
            end else if (advance) begin
                iv <= 1'b0;
            end
        end
    end

    // Divide/modulus-by-zero interception in front of the result register.
    // NOTE: all outputs of this block are assigned defaults first so no path
    // leaves them unassigned and no latch is inferred.
    always_comb begin
        cap_y     = alu_y;
        cap_flags = {1'b0, alu_n, alu_z, alu_c, alu_v, alu_e, alu_l};
        if ((alu_sel == SEL_DIV || alu_sel == SEL_MOD) && alu_b == 16'h0000) begin
            cap_y     = 16'hFFFF;
            cap_flags = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, alu_e, alu_l};
        end
    end

    // Result register, sticky status and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_y     <= '0;
            res_flags <= '0;
            sticky    <= '0;
            done_cnt  <= '0;
        end else begin
            if (advance) begin
                res_valid <= 1'b1;
                res_y     <= cap_y;
                res_flags <= cap_flags;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end

            // A capture in the same cycle as a clear wins: the word restarts
            // from the new capture's bits alone.
            if (advance) begin
                if (clr_sticky) sticky <= {cap_flags[6], cap_flags[2]};
                else            sticky <= sticky | {cap_flags[6], cap_flags[2]};
            end else if (clr_sticky) begin
                sticky <= '0;
            end

            if (res_valid && res_ready) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Self-checking bench for alu_op_sequencer. A behavioural ALU stand-in drives
// the alu_* inputs from the issue register. A reference model turns every
// accepted command into its expected {res_y, res_flags} and queues it; every
// handoff pops the queue in order. Directed sequences cover latency, sticky
// behaviour, backpressure, reset and counter wrap; random streams cover the
// rest.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_y;
    logic        alu_n, alu_z, alu_c, alu_v, alu_e, alu_l;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_y;
    logic [6:0]  res_flags;
    logic [1:0]  sticky;
    logic        clr_sticky = 1'b0;
    logic [15:0] done_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [22:0] exp_q[$];
    int          exp_done = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_y = '0;
    logic [6:0]  prev_flags = '0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_y      (alu_y),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .alu_e      (alu_e),
        .alu_l      (alu_l),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_y      (res_y),
        .res_flags  (res_flags),
        .sticky     (sticky),
        .clr_sticky (clr_sticky),
        .done_cnt   (done_cnt)
    );

    // ALU stand-in: returns {y, N, Z, C, V, E, L}. C is the carry/borrow of
    // ADD/SUB, V flags a MUL product that does not fit in 16 bits. Division
    // by zero yields an arbitrary value that the DUT must hide.
    function automatic logic [21:0] alu_fn(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        logic [16:0] w;
        logic [31:0] p;
        logic [15:0] y;
        logic        c;
        logic        v;
        logic [3:0]  s;
        s = b[3:0];
        c = 1'b0;
        v = 1'b0;
        w = {1'b0, a} + {1'b0, b};
        p = 32'(a) * 32'(b);
        case (op)
            4'd0:    begin y = w[15:0]; c = w[16]; end
            4'd1:    begin w = {1'b0, a} - {1'b0, b}; y = w[15:0]; c = w[16]; end
            4'd2:    begin y = p[15:0]; v = |p[31:16]; end
            4'd3:    y = (b == 16'd0) ? 16'd0 : a / b;
            4'd4:    y = (b == 16'd0) ? a : a % b;
            4'd5:    y = a & b;
            4'd6:    y = a | b;
            4'd7:    y = a ^ b;
            4'd8:    y = a << s;
            4'd9:    y = a >> s;
            4'd10:   y = 16'($signed(a) >>> s);
            4'd11:   y = (a << s) | (a >> (5'd16 - {1'b0, s}));
            4'd12:   y = (a >> s) | (a << (5'd16 - {1'b0, s}));
            4'd13:   y = ~(a & b);
            4'd14:   y = ~a;
            default: y = a;
        endcase
        return {y, y[15], (y == 16'd0), c, v, (a == b), (a < b)};
    endfunction

    assign {alu_y, alu_n, alu_z, alu_c, alu_v, alu_e, alu_l} = alu_fn(alu_sel, alu_a, alu_b);

    // Expected {res_y, res_flags} for one command.
    function automatic logic [22:0] model(input logic [3:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        logic [21:0] r;
        r = alu_fn(op, a, b);
        if ((op == 4'd3 || op == 4'd4) && b == 16'd0)
            return {16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, r[1], r[0]};
        return {r[21:6], 1'b0, r[5:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitor: samples on the falling edge, so every handshake seen here
    // completes on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_done   = 0;
            prev_stall = 1'b0;
        end else begin
            check("done_cnt", 32'(done_cnt), 32'(exp_done) & 32'h0000FFFF);
            if (prev_stall) begin
                check("stall_y", 32'(res_y), 32'(prev_y));
                check("stall_flags", 32'(res_flags), 32'(prev_flags));
            end
            if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_op, cmd_a, cmd_b));
            if (res_valid && res_ready) begin
                check("result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [22:0] e;
                    e = exp_q.pop_front();
                    check("res_y", 32'(res_y), 32'(e[22:7]));
                    check("res_flags", 32'(res_flags), 32'(e[6:0]));
                end
                exp_done++;
            end
            prev_stall = res_valid && !res_ready;
            prev_y     = res_y;
            prev_flags = res_flags;
        end
    end

    task automatic rand_cmd();
        cmd_op = 4'($urandom_range(0, 15));
        cmd_a  = 16'($urandom);
        cmd_b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
    endtask

    // Single command into an idle pipeline with res_ready low. Checks the
    // two-cycle latency and the issue register contents. clr_at_cap raises
    // clr_sticky exactly on the capture edge.
    task automatic issue_one(input logic [3:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic clr_at_cap);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        @(posedge clk); #1;                 // accept edge k
        cmd_valid = 1'b0;
        @(negedge clk);
        check("lat_k0_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;                 // edge k+1: issue register
        clr_sticky = clr_at_cap;
        @(negedge clk);
        check("lat_k1_valid", 32'(res_valid), 32'd0);
        check("issue_sel", 32'(alu_sel), 32'(op));
        check("issue_a", 32'(alu_a), 32'(a));
        check("issue_b", 32'(alu_b), 32'(b));
        @(posedge clk); #1;                 // edge k+2: capture
        clr_sticky = 1'b0;
        @(negedge clk);
        check("lat_k2_valid", 32'(res_valid), 32'd1);
    endtask

    task automatic handoff();
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    // Offer commands until n are accepted. mode 0 keeps res_ready, mode 1
    // toggles it every cycle, mode 2 randomizes both valid and ready.
    task automatic send_n(input int n, input int mode);
        int acc = 0;
        int cyc = 0;
        @(posedge clk); #1;
        while (acc < n && cyc < n * 3 + 50) begin
            rand_cmd();
            cmd_valid = (mode == 2) ? ($urandom_range(0, 9) < 7) : 1'b1;
            if (mode == 1)      res_ready = ~res_ready;
            else if (mode == 2) res_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (cmd_valid && cmd_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        cmd_valid = 1'b0;
        check("send_accepts", 32'(acc), 32'(n));
    endtask

    task automatic drain();
        int cyc = 0;
        @(posedge clk); #1;
        res_ready = 1'b1;
        while ((exp_q.size() != 0 || res_valid) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(res_valid), 32'd0);
    endtask

    initial begin
        int start_done;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_res_y", 32'(res_y), 32'd0);
        check("rst_res_flags", 32'(res_flags), 32'd0);
        check("rst_sticky", 32'(sticky), 32'd0);
        check("rst_alu", {alu_sel, alu_a, 12'(alu_b)}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Signed-boundary ADD.
        issue_one(4'd0, 16'h7FFF, 16'h0001, 1'b0);
        check("add_y", 32'(res_y), 32'h8000);
        check("add_flags", 32'(res_flags), 32'h20);
        handoff();
        @(negedge clk);
        check("add_done", 32'(done_cnt), 32'd1);

        // Divide by zero, then a lone clear.
        issue_one(4'd3, 16'h1234, 16'h0000, 1'b0);
        check("div0_y", 32'(res_y), 32'hFFFF);
        check("div0_flags", 32'(res_flags), 32'h64);
        check("div0_sticky", 32'(sticky), 32'd3);
        handoff();
        @(posedge clk); #1; clr_sticky = 1'b1;
        @(posedge clk); #1; clr_sticky = 1'b0;
        @(negedge clk);
        check("clr_sticky", 32'(sticky), 32'd0);

        // Clear coinciding with a capture: the capture's bits alone remain.
        issue_one(4'd3, 16'h0005, 16'h0000, 1'b0);
        check("sticky_set", 32'(sticky), 32'd3);
        handoff();
        issue_one(4'd0, 16'h0001, 16'h0001, 1'b1);
        check("clr_cap_clean", 32'(sticky), 32'd0);
        handoff();
        issue_one(4'd4, 16'h0007, 16'h0000, 1'b1);
        check("clr_cap_dz", 32'(sticky), 32'd3);
        handoff();

        // Backpressure burst: DEPTH+2 commands fit, then cmd_ready drops.
        res_ready = 1'b0;
        send_n(DEPTH + 2, 0);
        @(negedge clk);
        check("burst_full", 32'(cmd_ready), 32'd0);
        check("burst_valid", 32'(res_valid), 32'd1);
        @(posedge clk); #1; res_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            @(negedge clk);
            check("burst_b2b", 32'(res_valid), 32'd1);
        end
        @(negedge clk);
        check("burst_empty", 32'(res_valid), 32'd0);

        // res_ready toggling during a 20-command stream.
        start_done = exp_done;
        res_ready  = 1'b0;
        send_n(20, 1);
        drain();
        check("toggle_done", 32'(done_cnt), 32'(start_done + 20) & 32'h0000FFFF);

        // Random valid/ready stream.
        send_n(100, 2);
        drain();

        // Reset with the FIFO full and a result pending.
        @(posedge clk); #1; res_ready = 1'b0;
        send_n(DEPTH + 2, 0);
        @(negedge clk);
        check("pre_rst_full", 32'(cmd_ready), 32'd0);
        check("pre_rst_valid", 32'(res_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(res_valid), 32'd0);
        check("async_rst_ready", 32'(cmd_ready), 32'd1);
        check("async_rst_done", 32'(done_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        issue_one(4'd1, 16'd10, 16'd3, 1'b0);
        check("post_rst_y", 32'(res_y), 32'd7);
        handoff();
        @(negedge clk);
        check("post_rst_done", 32'(done_cnt), 32'd1);

        // Counter wrap: 65535 more handoffs bring done_cnt back to zero.
        @(posedge clk); #1; res_ready = 1'b1;
        send_n(65535, 0);
        drain();
        check("wrap_count", 32'(exp_done), 32'd65536);
        check("wrap_zero", 32'(done_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
